// File: rtl/nand_cmd_seq.sv
// ----------------------------------------------------------------------------
// nand_cmd_seq
//   Issues one NAND command sequence: CMD1, 0..5 address cycles, an optional
//   confirm command (CMD2), then an optional wait for R/B# with a timeout.
//   The first bus cycle is preceded by one set-up clock with CE#/CLE/data
//   valid and WE# high. Every bus cycle is TWP clocks WE# low followed by
//   TWH clocks WE# high, with CLE/ALE/DQ held for the whole cycle.
//
// Ports
//   cpld_50m_clk    : clock, everything on the rising edge
//   cpld_rst_n_50m  : asynchronous active-low reset
//   tick_en         : timeout prescale strobe (one count per high clock)
//   start           : command request, sampled only when idle
//   cmd1/cmd2       : first / confirm command bytes
//   cmd2_en         : send cmd2 after the address cycles
//   addr/addr_num   : address bytes (addr[7:0] first) and their count
//   busy_wait       : wait for R/B# after the last bus cycle
//   to_dly          : busy timeout in tick_en counts
//   rb_n            : NAND ready/busy, asynchronous to the clock
//   nand_*          : NAND bus outputs (all registered)
//   busy/done       : sequence active / one-clock completion pulse
//   timeout_err     : sticky R/B# timeout flag, cleared by the next start
// ----------------------------------------------------------------------------
module nand_cmd_seq #(
  parameter int TWP     = 2,
  parameter int TWH     = 2,
  parameter int TWB     = 5,
  parameter int TO_SIZE = 16
) (
  input  logic               cpld_50m_clk,
  input  logic               cpld_rst_n_50m,
  input  logic               tick_en,
  input  logic               start,
  input  logic [7:0]         cmd1,
  input  logic [7:0]         cmd2,
  input  logic               cmd2_en,
  input  logic [39:0]        addr,
  input  logic [2:0]         addr_num,
  input  logic               busy_wait,
  input  logic [TO_SIZE-1:0] to_dly,
  input  logic               rb_n,
  output logic               nand_ce_n,
  output logic               nand_cle,
  output logic               nand_ale,
  output logic               nand_we_n,
  output logic [7:0]         nand_dq_o,
  output logic               nand_dq_oe,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_ADDR, S_CMD2, S_TWBW, S_WAITRB, S_FIN
  } state_t;

  localparam logic [3:0] PH_LO_LAST = 4'(TWP - 1);
  localparam logic [3:0] PH_HI_LAST = 4'(TWH - 1);
  localparam logic [3:0] TWB_LAST   = 4'(TWB - 1);

  state_t               r_state;
  logic                 r_rb_meta;
  logic                 r_rb_s;
  logic [7:0]           r_cmd2;
  logic                 r_cmd2_pend;   // cmd2 still to be sent
  logic [39:0]          r_addr;        // shifts right one byte per ADDR cycle
  logic [2:0]           r_addr_left;   // ADDR cycles still to be sent
  logic                 r_busy_wait;
  logic [TO_SIZE-1:0]   r_to_dly;
  logic [TO_SIZE-1:0]   r_to_cnt;
  logic [3:0]           r_ph_cnt;      // clocks spent in the current WE# phase
  logic                 r_setup;       // set-up clock before the first WE# fall
  logic [3:0]           r_twb_cnt;
  logic                 r_ce_n;
  logic                 r_cle;
  logic                 r_ale;
  logic                 r_we_n;
  logic [7:0]           r_dq;
  logic                 r_oe;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_terr;

  logic [2:0]           w_addr_num_clip;

  assign w_addr_num_clip = (addr_num > 3'd5) ? 3'd5 : addr_num;

  // Two-flop synchroniser for the asynchronous R/B# pin.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge cpld_50m_clk or negedge cpld_rst_n_50m) begin
    if (!cpld_rst_n_50m) begin
      r_rb_meta <= 1'b0;
      r_rb_s    <= 1'b0;
    end else begin
      r_rb_meta <= rb_n;
      r_rb_s    <= r_rb_meta;
    end
  end

  always_ff @(posedge cpld_50m_clk or negedge cpld_rst_n_50m) begin
    if (!cpld_rst_n_50m) begin
      // NOTE: every register here is a small control flop, so all of them get
      // an asynchronous reset; there is no storage array that would need to
      // stay unreset.
      r_state     <= S_IDLE;
      r_cmd2      <= 8'h00;
      r_cmd2_pend <= 1'b0;
      r_addr      <= '0;
      r_addr_left <= 3'd0;
      r_busy_wait <= 1'b0;
      r_to_dly    <= '0;
      r_to_cnt    <= '0;
      r_ph_cnt    <= 4'd0;
      r_setup     <= 1'b0;
      r_twb_cnt   <= 4'd0;
      r_ce_n      <= 1'b1;
      r_cle       <= 1'b0;
      r_ale       <= 1'b0;
      r_we_n      <= 1'b1;
      r_dq        <= 8'h00;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_CMD1;
            r_ce_n      <= 1'b0;
            r_busy      <= 1'b1;
            r_terr      <= 1'b0;
            r_cle       <= 1'b1;
            r_ale       <= 1'b0;
            r_dq        <= cmd1;
            r_oe        <= 1'b1;
            r_we_n      <= 1'b1;
            r_setup     <= 1'b1;
            r_ph_cnt    <= 4'd0;
            r_cmd2      <= cmd2;
            r_cmd2_pend <= cmd2_en;
            r_addr      <= addr;
            r_addr_left <= w_addr_num_clip;
            r_busy_wait <= busy_wait;
            r_to_dly    <= to_dly;
          end
        end

        // All three bus states share one WE# engine; the state only records
        // which kind of cycle is on the bus.
        S_CMD1, S_ADDR, S_CMD2: begin
          if (r_setup) begin
            r_setup  <= 1'b0;
            r_we_n   <= 1'b0;
            r_ph_cnt <= 4'd0;
          end else if (!r_we_n) begin
            if (r_ph_cnt == PH_LO_LAST) begin
              r_we_n   <= 1'b1;
              r_ph_cnt <= 4'd0;
            end else begin
              r_ph_cnt <= r_ph_cnt + 4'd1;
            end
          end else if (r_ph_cnt != PH_HI_LAST) begin
            r_ph_cnt <= r_ph_cnt + 4'd1;
          end else begin
            // End of a bus cycle: CLE/ALE/DQ change together with the next
            // WE# fall, so they never move while WE# is rising.
            r_ph_cnt <= 4'd0;
            if (r_addr_left != 3'd0) begin
              r_state     <= S_ADDR;
              r_we_n      <= 1'b0;
              r_cle       <= 1'b0;
              r_ale       <= 1'b1;
              r_dq        <= r_addr[7:0];
              r_addr      <= r_addr >> 8;
              r_addr_left <= r_addr_left - 3'd1;
            end else if (r_cmd2_pend) begin
              r_state     <= S_CMD2;
              r_we_n      <= 1'b0;
              r_cle       <= 1'b1;
              r_ale       <= 1'b0;
              r_dq        <= r_cmd2;
              r_cmd2_pend <= 1'b0;
            end else begin
              r_cle <= 1'b0;
              r_ale <= 1'b0;
              r_dq  <= 8'h00;
              r_oe  <= 1'b0;
              if (r_busy_wait) begin
                r_state   <= S_TWBW;
                r_twb_cnt <= 4'd0;
              end else begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
                r_ce_n  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end
          end
        end

        // R/B# is not valid until tWB after the last WE# rise.
        S_TWBW: begin
          if (r_twb_cnt == TWB_LAST) begin
            r_state  <= S_WAITRB;
            r_to_cnt <= '0;
          end else begin
            r_twb_cnt <= r_twb_cnt + 4'd1;
          end
        end

        // Ready wins over a timeout in the same clock; the counter only
        // advances while below to_dly, so it saturates instead of wrapping.
        S_WAITRB: begin
          if (r_rb_s) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_ce_n  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_to_cnt >= r_to_dly) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_ce_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_terr  <= 1'b1;
          end else if (tick_en) begin
            r_to_cnt <= r_to_cnt + TO_SIZE'(1);
          end
        end

        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign nand_ce_n   = r_ce_n;
  assign nand_cle    = r_cle;
  assign nand_ale    = r_ale;
  assign nand_we_n   = r_we_n;
  assign nand_dq_o   = r_dq;
  assign nand_dq_oe  = r_oe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_nand_cmd_seq.sv
// ----------------------------------------------------------------------------
// tb_nand_cmd_seq
//   Table of complete command sequences with hand-computed completion times,
//   plus directed sequences for back-to-back start and reset mid-sequence.
//   Sample index k counts falling clock edges after the accepting rising edge.
// ----------------------------------------------------------------------------
module tb_nand_cmd_seq;

  localparam int TWP = 2;
  localparam int TWH = 2;
  localparam logic [15:0] RST_OUTS = {1'b1, 1'b1, 2'b00, 8'h00, 4'b0000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_en;
  logic        start;
  logic [7:0]  cmd1;
  logic [7:0]  cmd2;
  logic        cmd2_en;
  logic [39:0] addr;
  logic [2:0]  addr_num;
  logic        busy_wait;
  logic [15:0] to_dly;
  logic        rb_n;
  logic        nand_ce_n;
  logic        nand_cle;
  logic        nand_ale;
  logic        nand_we_n;
  logic [7:0]  nand_dq_o;
  logic        nand_dq_oe;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  nand_cmd_seq dut (
    .cpld_50m_clk   (clk),
    .cpld_rst_n_50m (rst_n),
    .tick_en        (tick_en),
    .start          (start),
    .cmd1           (cmd1),
    .cmd2           (cmd2),
    .cmd2_en        (cmd2_en),
    .addr           (addr),
    .addr_num       (addr_num),
    .busy_wait      (busy_wait),
    .to_dly         (to_dly),
    .rb_n           (rb_n),
    .nand_ce_n      (nand_ce_n),
    .nand_cle       (nand_cle),
    .nand_ale       (nand_ale),
    .nand_we_n      (nand_we_n),
    .nand_dq_o      (nand_dq_o),
    .nand_dq_oe     (nand_dq_oe),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  cmd1;
    logic [7:0]  cmd2;
    logic        cmd2_en;
    logic [39:0] addr;
    logic [2:0]  addr_num;
    logic        busy_wait;
    logic [15:0] to_dly;
    int          tick_per;   // tick_en high on samples k % tick_per == 0
    int          rb_rise;    // rb_n high from sample rb_rise on
    int          glitch_k;   // re-pulse start and scramble inputs here (0: none)
    int          exp_done;   // sample index of the done pulse
    logic        exp_terr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {nand_ce_n, nand_we_n, nand_cle, nand_ale, nand_dq_o,
            nand_dq_oe, busy, done, timeout_err};
  endfunction

  // Runs one command; must be called right after a falling edge.
  task automatic run_vec(input vec_t v, input int idx);
    logic [9:0]  exp_cyc[8];
    logic [9:0]  obs[8];
    logic [10:0] snap;
    logic [10:0] bus_now;
    logic [2:0]  acc;
    logic [1:0]  bce_at_done;
    logic        terr_done;
    logic        prev_we;
    logic        in_hi;
    int n_exp, an, done_k, done_cnt, ce_pre, ce_post, ncyc;
    int bad_tim, bad_stab, lo_len, hi_len;

    an = (v.addr_num > 3'd5) ? 5 : int'(v.addr_num);
    exp_cyc[0] = {2'b10, v.cmd1};
    n_exp = 1;
    for (int i = 0; i < an; i++) begin
      exp_cyc[n_exp] = {2'b01, v.addr[8*i +: 8]};
      n_exp++;
    end
    if (v.cmd2_en) begin
      exp_cyc[n_exp] = {2'b10, v.cmd2};
      n_exp++;
    end

    done_k = 0; done_cnt = 0; ce_pre = 0; ce_post = 0; ncyc = 0;
    bad_tim = 0; bad_stab = 0; lo_len = 0; hi_len = 0;
    prev_we = 1'b1; in_hi = 1'b0; snap = '0;
    acc = '0; bce_at_done = '0; terr_done = 1'b0;

    cmd1 = v.cmd1; cmd2 = v.cmd2; cmd2_en = v.cmd2_en; addr = v.addr;
    addr_num = v.addr_num; busy_wait = v.busy_wait; to_dly = v.to_dly;
    tick_en = 1'b0; rb_n = (v.rb_rise <= 0); start = 1'b1;

    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      bus_now = {nand_cle, nand_ale, nand_dq_o, nand_dq_oe};
      if (k == 1) begin
        start = 1'b0;
        acc = {nand_ce_n, busy, timeout_err};
      end
      if (done) begin
        if (done_k == 0) begin
          done_k = k;
          bce_at_done = {busy, nand_ce_n};
          terr_done = timeout_err;
        end
        done_cnt++;
      end
      if (!nand_ce_n) begin
        if (done_k == 0) ce_pre++;
        else ce_post++;
      end
      // WE# phase lengths and bus stability across each cycle.
      if (!nand_we_n) begin
        if (prev_we) begin
          if (in_hi) begin
            if (hi_len != TWH) bad_tim++;
            in_hi = 1'b0;
          end
          if (!nand_dq_oe) bad_stab++;
          lo_len = 1;
          snap = bus_now;
        end else begin
          lo_len++;
          if (bus_now !== snap) bad_stab++;
        end
      end else if (!prev_we) begin
        if (lo_len != TWP) bad_tim++;
        if (bus_now !== snap) bad_stab++;
        if (ncyc < 8) obs[ncyc] = bus_now[10:1];
        ncyc++;
        in_hi = 1'b1;
        hi_len = 1;
      end else if (in_hi) begin
        if (nand_dq_oe) begin
          hi_len++;
          if (bus_now !== snap) bad_stab++;
        end else begin
          if (hi_len != TWH) bad_tim++;
          in_hi = 1'b0;
        end
      end
      prev_we = nand_we_n;

      if (k == v.glitch_k) begin
        start = 1'b1; cmd1 = ~v.cmd1; cmd2 = ~v.cmd2; cmd2_en = ~v.cmd2_en;
        addr = ~v.addr; addr_num = 3'd1; busy_wait = ~v.busy_wait; to_dly = 16'd0;
      end
      if (v.glitch_k != 0 && k == v.glitch_k + 1) start = 1'b0;
      tick_en = (k % v.tick_per == 0);
      rb_n = (k >= v.rb_rise);
      if (done_k != 0 && k >= done_k + 3) break;
    end
    tick_en = 1'b0;

    check($sformatf("v%0d_accept", idx), acc, 3'b010);
    check($sformatf("v%0d_ncycles", idx), ncyc, n_exp);
    for (int i = 0; i < n_exp; i++)
      check($sformatf("v%0d_cycle%0d", idx, i), obs[i], exp_cyc[i]);
    check($sformatf("v%0d_we_timing", idx), bad_tim, 0);
    check($sformatf("v%0d_bus_stable", idx), bad_stab, 0);
    check($sformatf("v%0d_done_at", idx), done_k, v.exp_done);
    check($sformatf("v%0d_done_width", idx), done_cnt, 1);
    check($sformatf("v%0d_busy_ce_at_done", idx), bce_at_done, 2'b01);
    check($sformatf("v%0d_terr_at_done", idx), terr_done, v.exp_terr);
    check($sformatf("v%0d_ce_low_clks", idx), ce_pre, v.exp_done - 1);
    check($sformatf("v%0d_ce_after_done", idx), ce_post, 0);
    check($sformatf("v%0d_terr_sticky", idx), timeout_err, v.exp_terr);
  endtask

  initial begin
    logic got;
    int   dcnt;

    // cmd1, cmd2, cmd2_en, addr, addr_num, busy_wait, to_dly,
    // tick_per, rb_rise, glitch_k, exp_done, exp_terr
    vecs[0] = '{8'hFF, 8'h00, 1'b0, 40'h0, 3'd0, 1'b0, 16'd0,    1, 0,    0,  6, 1'b0};
    vecs[1] = '{8'h00, 8'h30, 1'b1, 40'h04_0302_0100, 3'd5, 1'b1, 16'd1000,
                1, 69, 0, 72, 1'b0};
    vecs[2] = '{8'h90, 8'h00, 1'b0, 40'hEE_DDCC_BBAA, 3'd7, 1'b0, 16'd0,
                1, 0, 10, 26, 1'b0};
    vecs[3] = '{8'h60, 8'hD0, 1'b1, 40'h00_0003_0201, 3'd3, 1'b1, 16'd3,
                10, 9999, 0, 52, 1'b1};
    vecs[4] = '{8'hE0, 8'h00, 1'b0, 40'h0, 3'd0, 1'b1, 16'd0,   1, 9999, 0, 12, 1'b1};
    vecs[5] = '{8'hE1, 8'h00, 1'b0, 40'h0, 3'd0, 1'b1, 16'd2,   1, 11,   0, 14, 1'b0};
    vecs[6] = '{8'h85, 8'h10, 1'b1, 40'h00_0000_789A, 3'd2, 1'b0, 16'd0,
                1, 0, 0, 18, 1'b0};

    rst_n = 1'b0; tick_en = 1'b0; start = 1'b0; cmd1 = 8'h00; cmd2 = 8'h00;
    cmd2_en = 1'b0; addr = '0; addr_num = 3'd0; busy_wait = 1'b0;
    to_dly = 16'd0; rb_n = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), RST_OUTS);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs(), RST_OUTS);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Start asserted in the IDLE clock right after done is accepted.
    cmd1 = 8'hFF; addr_num = 3'd0; cmd2_en = 1'b0; busy_wait = 1'b0;
    rb_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("b2b_done1", got, 1'b1);
    @(negedge clk);
    check("b2b_idle_ce", nand_ce_n, 1'b1);
    cmd1 = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept", {nand_ce_n, busy, nand_dq_o}, {1'b0, 1'b1, 8'hA5});
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("b2b_done2", got, 1'b1);
    @(negedge clk);

    // Reset in the second ADDR cycle of a read-page sequence.
    cmd1 = 8'h00; cmd2 = 8'h30; cmd2_en = 1'b1; addr = 40'h04_0302_0100;
    addr_num = 3'd5; busy_wait = 1'b1; to_dly = 16'd1000; rb_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_in_addr1", {nand_ale, nand_we_n, nand_dq_o}, {1'b1, 1'b0, 8'h01});
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", outs(), RST_OUTS);
    dcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    check("midrst_held", outs(), RST_OUTS);
    rst_n = 1'b1;
    run_vec(vecs[1], 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
